// File: rtl/render_pkg.sv
// Shared constants, colour payload and helpers for the board renderer.
package render_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = '{r: 2'b00, g: 2'b00, b: 2'b00};
  localparam rgb_t COL_BG     = '{r: 2'b01, g: 2'b11, b: 2'b01};
  localparam rgb_t COL_BOARD  = '{r: 2'b00, g: 2'b00, b: 2'b11};
  localparam rgb_t COL_P1     = '{r: 2'b11, g: 2'b11, b: 2'b00};
  localparam rgb_t COL_P2     = '{r: 2'b11, g: 2'b00, b: 2'b00};
  localparam rgb_t COL_HILITE = '{r: 2'b11, g: 2'b11, b: 2'b11};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_LAND = 2'd2
  } anim_state_t;

  // Colour of a piece code; anything that is not a player shows as background.
  function automatic rgb_t piece_colour(input logic [1:0] code);
    case (code)
      CELL_P1: return COL_P1;
      CELL_P2: return COL_P2;
      default: return COL_BG;
    endcase
  endfunction

  // Square of a signed 11-bit offset as an unsigned 22-bit value.
  function automatic logic [21:0] sq11(input logic signed [10:0] v);
    logic signed [21:0] p;
    p = 22'(v) * 22'(v);
    return unsigned'(p);
  endfunction

  // Inclusive circle test on a pair of offsets.
  function automatic logic in_circle(input logic signed [10:0] dx,
                                     input logic signed [10:0] dy,
                                     input logic [21:0]        r2);
    logic [21:0] s;
    s = sq11(dx) + sq11(dy);
    return (s <= r2);
  endfunction

endpackage

// File: rtl/drop_animator.sv
// Falling-piece animator: accepts one drop at a time and steps it down per frame.
module drop_animator
  import render_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned CELL_LOG2  = 5,
  parameter int unsigned ORIGIN_Y   = 112,
  parameter int unsigned CURSOR_GAP = 16,
  parameter int unsigned FALL_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  input  logic [2:0] drop_row,
  input  logic [1:0] drop_player,
  output logic       drop_ready,
  output logic       anim_busy,
  output logic       falling,
  output logic [9:0] fall_y,
  output logic [2:0] fall_col,
  output logic [2:0] fall_row,
  output logic [1:0] fall_player
);

  localparam int unsigned CELL    = 1 << CELL_LOG2;
  localparam int unsigned HALF    = CELL / 2;
  localparam int unsigned START_Y = ORIGIN_Y - CURSOR_GAP - HALF;

  anim_state_t state;
  logic [10:0] target_y_c;
  logic [10:0] step_sum_c;
  logic        drop_ok_c;

  // Landing centre, next step position and range-checked request.
  always_comb begin
    target_y_c = 11'(ORIGIN_Y + HALF) + (11'(fall_row) << CELL_LOG2);
    step_sum_c = {1'b0, fall_y} + 11'(FALL_STEP);
    drop_ok_c  = drop_valid && (4'(drop_col) < 4'(COLS)) && (4'(drop_row) < 4'(ROWS));
  end

  // Animator FSM with registered handshake and drop fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fall_y      <= '0;
      fall_col    <= '0;
      fall_row    <= '0;
      fall_player <= '0;
      drop_ready  <= 1'b1;
      anim_busy   <= 1'b0;
      falling     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (drop_ok_c) begin
            fall_col    <= drop_col;
            fall_row    <= drop_row;
            fall_player <= drop_player;
            fall_y      <= 10'(START_Y);
            state       <= ST_FALL;
            drop_ready  <= 1'b0;
            anim_busy   <= 1'b1;
            falling     <= 1'b1;
          end
        end
        ST_FALL: begin
          if (frame_tick) begin
            if (step_sum_c >= target_y_c) begin
              fall_y  <= 10'(target_y_c);
              state   <= ST_LAND;
              falling <= 1'b0;
            end else begin
              fall_y <= 10'(step_sum_c);
            end
          end
        end
        ST_LAND: begin
          if (frame_tick) begin
            state      <= ST_IDLE;
            drop_ready <= 1'b1;
            anim_busy  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          drop_ready <= 1'b1;
          anim_busy  <= 1'b0;
          falling    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Two-stage Connect Four pixel renderer with drop animation and win blinking.
module board_renderer
  import render_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned CELL_LOG2  = 5,
  parameter int unsigned ORIGIN_X   = 192,
  parameter int unsigned ORIGIN_Y   = 112,
  parameter int unsigned CURSOR_GAP = 16,
  parameter int unsigned RADIUS     = 14,
  parameter int unsigned FALL_STEP  = 4,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               x_count,
  input  logic [9:0]               y_count,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic [2*ROWS*COLS-1:0]   board,
  input  logic [2:0]               current_col,
  input  logic [1:0]               current_player,
  input  logic                     game_over,
  input  logic [ROWS*COLS-1:0]     win_mask,
  input  logic                     drop_valid,
  input  logic [2:0]               drop_col,
  input  logic [2:0]               drop_row,
  input  logic [1:0]               drop_player,
  output logic                     drop_ready,
  output logic                     anim_busy,
  output logic                     hsync,
  output logic                     vsync,
  output logic [1:0]               vga_r,
  output logic [1:0]               vga_g,
  output logic [1:0]               vga_b
);

  localparam int unsigned CELL    = 1 << CELL_LOG2;
  localparam int unsigned HALF    = CELL / 2;
  localparam int unsigned BOARD_W = COLS * CELL;
  localparam int unsigned BOARD_H = ROWS * CELL;
  localparam int unsigned CUR_Y   = ORIGIN_Y - CURSOR_GAP - HALF;
  localparam int unsigned CNT_W   = BLINK_LOG2 + 1;
  localparam logic [21:0] R2      = 22'(RADIUS * RADIUS);

  logic       frame_tick_c;
  logic       anim_falling;
  logic [9:0] anim_fall_y;
  logic [2:0] anim_fall_col;
  logic [2:0] anim_fall_row;
  logic [1:0] anim_fall_player;

  logic [CNT_W-1:0] frame_cnt;

  // Start of vertical blanking marks one frame.
  assign frame_tick_c = (x_count == 10'd0) && (y_count == 10'(V_ACTIVE));

  drop_animator #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .CELL_LOG2  (CELL_LOG2),
    .ORIGIN_Y   (ORIGIN_Y),
    .CURSOR_GAP (CURSOR_GAP),
    .FALL_STEP  (FALL_STEP)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick_c),
    .drop_valid  (drop_valid),
    .drop_col    (drop_col),
    .drop_row    (drop_row),
    .drop_player (drop_player),
    .drop_ready  (drop_ready),
    .anim_busy   (anim_busy),
    .falling     (anim_falling),
    .fall_y      (anim_fall_y),
    .fall_col    (anim_fall_col),
    .fall_row    (anim_fall_row),
    .fall_player (anim_fall_player)
  );

  // Free-running frame counter; its top bit is the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_tick_c) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // ---------------- stage 1: geometry ----------------
  logic [10:0]        x_ext_c, y_ext_c, x_off_c, y_off_c;
  logic [10:0]        cur_x_c, fall_x_c;
  logic               active_c, in_board_c, target_c;
  logic [2:0]         row_c, col_c;
  logic signed [10:0] cell_dx_c, cell_dy_c, cur_dx_c, cur_dy_c, fall_dx_c, fall_dy_c;

  // Beam offsets relative to the cell, cursor and falling-piece centres.
  always_comb begin
    x_ext_c    = {1'b0, x_count};
    y_ext_c    = {1'b0, y_count};
    active_c   = (x_count < 10'(H_ACTIVE)) && (y_count < 10'(V_ACTIVE));
    x_off_c    = x_ext_c - 11'(ORIGIN_X);
    y_off_c    = y_ext_c - 11'(ORIGIN_Y);
    in_board_c = (x_ext_c >= 11'(ORIGIN_X)) && (x_ext_c < 11'(ORIGIN_X + BOARD_W)) &&
                 (y_ext_c >= 11'(ORIGIN_Y)) && (y_ext_c < 11'(ORIGIN_Y + BOARD_H));
    col_c      = in_board_c ? 3'(x_off_c >> CELL_LOG2) : 3'd0;
    row_c      = in_board_c ? 3'(y_off_c >> CELL_LOG2) : 3'd0;
    cell_dx_c  = (x_off_c & 11'(CELL - 1)) - 11'(HALF);
    cell_dy_c  = (y_off_c & 11'(CELL - 1)) - 11'(HALF);
    cur_x_c    = 11'(ORIGIN_X + HALF) + (11'(current_col) << CELL_LOG2);
    cur_dx_c   = x_ext_c - cur_x_c;
    cur_dy_c   = y_ext_c - 11'(CUR_Y);
    fall_x_c   = 11'(ORIGIN_X + HALF) + (11'(anim_fall_col) << CELL_LOG2);
    fall_dx_c  = x_ext_c - fall_x_c;
    fall_dy_c  = y_ext_c - {1'b0, anim_fall_y};
    target_c   = anim_falling && in_board_c &&
                 (row_c == anim_fall_row) && (col_c == anim_fall_col);
  end

  logic               s1_hsync, s1_vsync, s1_active, s1_in_board;
  logic               s1_falling, s1_target, s1_busy, s1_blink;
  logic [2:0]         s1_row, s1_col;
  logic [1:0]         s1_fall_player;
  logic signed [10:0] s1_cell_dx, s1_cell_dy, s1_cur_dx, s1_cur_dy, s1_fall_dx, s1_fall_dy;

  // Stage 1 register: syncs, cell indices, offsets and a snapshot of animation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hsync       <= 1'b1;
      s1_vsync       <= 1'b1;
      s1_active      <= 1'b0;
      s1_in_board    <= 1'b0;
      s1_falling     <= 1'b0;
      s1_target      <= 1'b0;
      s1_busy        <= 1'b0;
      s1_blink       <= 1'b0;
      s1_row         <= '0;
      s1_col         <= '0;
      s1_fall_player <= '0;
      s1_cell_dx     <= '0;
      s1_cell_dy     <= '0;
      s1_cur_dx      <= '0;
      s1_cur_dy      <= '0;
      s1_fall_dx     <= '0;
      s1_fall_dy     <= '0;
    end else begin
      s1_hsync       <= hsync_in;
      s1_vsync       <= vsync_in;
      s1_active      <= active_c;
      s1_in_board    <= in_board_c;
      s1_falling     <= anim_falling;
      s1_target      <= target_c;
      s1_busy        <= anim_busy;
      s1_blink       <= frame_cnt[BLINK_LOG2];
      s1_row         <= row_c;
      s1_col         <= col_c;
      s1_fall_player <= anim_fall_player;
      s1_cell_dx     <= cell_dx_c;
      s1_cell_dy     <= cell_dy_c;
      s1_cur_dx      <= cur_dx_c;
      s1_cur_dy      <= cur_dy_c;
      s1_fall_dx     <= fall_dx_c;
      s1_fall_dy     <= fall_dy_c;
    end
  end

  // ---------------- stage 2: colour ----------------
  logic [127:0] board_pad_c;
  logic [63:0]  win_pad_c;
  logic [5:0]   idx_c;
  logic [1:0]   cell_code_c;
  logic         win_c, in_cell_c, in_cur_c, in_fall_c;
  rgb_t         pix_c;

  // Priority mux: falling piece, board, cursor, background.
  always_comb begin
    board_pad_c = 128'(board);
    win_pad_c   = 64'(win_mask);
    idx_c       = 6'(s1_row) * 6'(COLS) + 6'(s1_col);
    cell_code_c = board_pad_c[{idx_c, 1'b0} +: 2];
    win_c       = win_pad_c[idx_c];
    in_cell_c   = in_circle(s1_cell_dx, s1_cell_dy, R2);
    in_cur_c    = in_circle(s1_cur_dx, s1_cur_dy, R2);
    in_fall_c   = in_circle(s1_fall_dx, s1_fall_dy, R2);
    pix_c       = COL_BLACK;
    if (s1_active) begin
      if (s1_falling && in_fall_c) begin
        pix_c = piece_colour(s1_fall_player);
      end else if (s1_in_board) begin
        if (!in_cell_c) begin
          pix_c = COL_BOARD;
        end else if (s1_target) begin
          pix_c = COL_BG;
        end else if (win_c && game_over && !s1_blink) begin
          pix_c = COL_HILITE;
        end else begin
          pix_c = piece_colour(cell_code_c);
        end
      end else if (in_cur_c && !game_over && !s1_busy) begin
        pix_c = piece_colour(current_player);
      end else begin
        pix_c = COL_BG;
      end
    end
  end

  // Stage 2 register: pixel colour and matching syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      vga_r <= pix_c.r;
      vga_g <= pix_c.g;
      vga_b <= pix_c.b;
      hsync <= s1_hsync;
      vsync <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: drivers queue expectations, a monitor checks them.
module tb_board_renderer;

  localparam int K_PIX   = 0;
  localparam int K_STAT  = 1;
  localparam int K_PIX6  = 2;
  localparam int K_STAT6 = 3;

  localparam logic [5:0] C_OFF   = 6'b000000;
  localparam logic [5:0] C_BG    = 6'b011101;
  localparam logic [5:0] C_BOARD = 6'b000011;
  localparam logic [5:0] C_P1    = 6'b111100;
  localparam logic [5:0] C_P2    = 6'b110000;
  localparam logic [5:0] C_HI    = 6'b111111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   x_count, y_count;
  logic         hsync_in, vsync_in;
  logic [127:0] board;
  logic [83:0]  board6;
  logic [2:0]   current_col;
  logic [1:0]   current_player;
  logic         game_over;
  logic [63:0]  win_mask;
  logic [41:0]  win6;
  logic         drop_valid, drop_valid6;
  logic [2:0]   drop_col, drop_row, drop_col6, drop_row6;
  logic [1:0]   drop_player;

  logic       drop_ready, anim_busy, hsync, vsync;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       drop_ready6, anim_busy6, hsync6, vsync6;
  logic [1:0] vga_r6, vga_g6, vga_b6;

  always #5 clk = ~clk;

  board_renderer #(.BLINK_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .x_count(x_count), .y_count(y_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board),
    .current_col(current_col), .current_player(current_player),
    .game_over(game_over), .win_mask(win_mask), .drop_valid(drop_valid),
    .drop_col(drop_col), .drop_row(drop_row), .drop_player(drop_player),
    .drop_ready(drop_ready), .anim_busy(anim_busy), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  board_renderer #(.ROWS(6), .COLS(7), .CELL_LOG2(4), .RADIUS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .x_count(x_count), .y_count(y_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board6),
    .current_col(current_col), .current_player(current_player),
    .game_over(game_over), .win_mask(win6), .drop_valid(drop_valid6),
    .drop_col(drop_col6), .drop_row(drop_row6), .drop_player(drop_player),
    .drop_ready(drop_ready6), .anim_busy(anim_busy6), .hsync(hsync6), .vsync(vsync6),
    .vga_r(vga_r6), .vga_g(vga_g6), .vga_b(vga_b6)
  );

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ticks_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int delay, input int kind, input logic [7:0] e, input string tag);
    sb.push_back('{due: cyc + delay, kind: kind, exp: e, tag: tag});
  endtask

  task automatic check_entry(input exp_t e);
    logic [7:0] act;
    case (e.kind)
      K_PIX:   act = {vga_r, vga_g, vga_b, hsync, vsync};
      K_STAT:  act = {6'b0, anim_busy, drop_ready};
      K_PIX6:  act = {vga_r6, vga_g6, vga_b6, hsync6, vsync6};
      default: act = {6'b0, anim_busy6, drop_ready6};
    endcase
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)", e.tag, act, e.exp, cyc);
    end
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe_s(input int which, input int x, input int y, input logic hs,
                         input logic vs, input logic [5:0] rgb, input string tag);
    @(negedge clk);
    x_count  = 10'(x);
    y_count  = 10'(y);
    hsync_in = hs;
    vsync_in = vs;
    expect_at(2, (which != 0) ? K_PIX6 : K_PIX, {rgb, hs, vs}, tag);
  endtask

  task automatic probe(input int which, input int x, input int y, input logic [5:0] rgb,
                       input string tag);
    probe_s(which, x, y, 1'b1, 1'b1, rgb, tag);
  endtask

  task automatic tick();
    @(negedge clk);
    x_count = 10'd0;
    y_count = 10'd480;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    ticks_seen++;
    @(negedge clk);
    x_count = 10'd700;
    y_count = 10'd500;
  endtask

  task automatic check_status(input int which, input logic [7:0] e, input string tag);
    @(negedge clk);
    expect_at(1, (which != 0) ? K_STAT6 : K_STAT, e, tag);
  endtask

  task automatic drop(input int which, input logic [2:0] col, input logic [2:0] row,
                      input logic [1:0] pl, input logic [7:0] e, input string tag);
    @(negedge clk);
    drop_player = pl;
    if (which != 0) begin
      drop_valid6 = 1'b1; drop_col6 = col; drop_row6 = row;
    end else begin
      drop_valid = 1'b1; drop_col = col; drop_row = row;
    end
    expect_at(1, (which != 0) ? K_STAT6 : K_STAT, e, tag);
    @(negedge clk);
    drop_valid  = 1'b0;
    drop_valid6 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  row7;
    logic [5:0]  hi_or_p2, hi_or_p1;
    rst_n = 1'b0;
    x_count = 10'd700; y_count = 10'd500;
    hsync_in = 1'b1; vsync_in = 1'b1;
    board = '0; board6 = '0; win_mask = '0; win6 = '0;
    current_col = 3'd3; current_player = 2'b01; game_over = 1'b0;
    drop_valid = 1'b0; drop_valid6 = 1'b0;
    drop_col = '0; drop_row = '0; drop_col6 = '0; drop_row6 = '0; drop_player = 2'b01;

    // Reset state
    idle(2);
    expect_at(1, K_PIX, {C_OFF, 2'b11}, "reset_rgb");
    expect_at(1, K_STAT, 8'b01, "reset_status");
    expect_at(1, K_STAT6, 8'b01, "reset_status6");
    @(negedge clk);
    rst_n = 1'b1;

    // Cursor, sync delay, blanking
    probe_s(0, 304, 80, 1'b0, 1'b1, C_P1, "cursor_centre_hsync");
    probe(0, 318, 80, C_P1, "cursor_edge_in");
    probe(0, 319, 80, C_BG, "cursor_edge_out");
    probe(0, 304, 94, C_P1, "cursor_bottom_in");
    probe(0, 304, 95, C_BG, "cursor_bottom_out");
    probe_s(0, 640, 100, 1'b1, 1'b0, C_OFF, "h_blank_vsync");
    probe(0, 100, 480, C_OFF, "v_blank");

    // Board contents: (7,0)=P2, (7,1..3)=P1
    idle(2);
    row7 = 8'b01010110;
    board[119:112] = row7;
    probe(0, 208, 352, C_P2, "cell_7_0_centre");
    probe(0, 193, 113, C_BOARD, "cell_0_0_corner");
    probe(0, 240, 352, C_P1, "cell_7_1_centre");
    probe(0, 336, 352, C_BG, "cell_7_4_empty");
    probe(0, 191, 113, C_BG, "left_of_board");
    probe(0, 447, 200, C_BOARD, "board_right_edge");
    probe(0, 448, 200, C_BG, "right_of_board");

    // Drop animation at column 2, row 7
    drop(0, 3'd2, 3'd7, 2'b01, 8'b10, "drop_accept");
    probe(0, 272, 80, C_P1, "fall_start");
    probe(0, 304, 80, C_BG, "cursor_hidden_busy");
    probe(0, 272, 352, C_BG, "target_empty_fall");
    tick();
    drop(0, 3'd5, 3'd0, 2'b10, 8'b10, "second_drop_ignored");
    probe(0, 272, 98, C_P1, "fall_after_tick1");
    probe(0, 272, 99, C_BG, "fall_after_tick1_edge");
    repeat (66) tick();
    check_status(0, 8'b10, "busy_after_67");
    probe(0, 272, 362, C_P1, "fall_after_67");
    probe(0, 272, 363, C_BG, "target_below_piece");
    tick();
    check_status(0, 8'b10, "land_after_68");
    probe(0, 272, 352, C_P1, "landed_cell_shown");
    probe(0, 304, 80, C_BG, "cursor_hidden_land");
    tick();
    check_status(0, 8'b01, "idle_after_69");
    probe(0, 304, 80, C_P1, "cursor_back");

    // Win highlight blinking
    idle(2);
    game_over = 1'b1;
    win_mask[59:56] = 4'hF;
    for (int f = 0; f < 5; f++) begin
      hi_or_p2 = (((ticks_seen >> 1) & 1) == 0) ? C_HI : C_P2;
      hi_or_p1 = (((ticks_seen >> 1) & 1) == 0) ? C_HI : C_P1;
      probe(0, 208, 352, hi_or_p2, "blink_7_0");
      probe(0, 240, 352, hi_or_p1, "blink_7_1");
      probe(0, 304, 80, C_BG, "cursor_hidden_game_over");
      probe(0, 193, 337, C_BOARD, "win_cell_outside_circle");
      tick();
    end
    probe(0, 336, 352, C_BG, "non_win_cell");

    // Alternative geometry instance
    probe(1, 304, 150, C_BG, "g6_outside_right");
    probe(1, 303, 150, C_BOARD, "g6_inside_right");
    probe(1, 193, 113, C_BOARD, "g6_corner");
    probe(1, 200, 120, C_BG, "g6_cell_centre");
    drop(1, 3'd0, 3'd6, 2'b01, 8'b01, "g6_row6_ignored");
    check_status(1, 8'b01, "g6_still_ready");

    // Reset in the middle of a fall
    idle(2);
    game_over = 1'b0;
    win_mask = '0;
    drop(0, 3'd4, 3'd6, 2'b01, 8'b10, "drop_before_reset");
    tick();
    tick();
    probe(0, 336, 88, C_P1, "fall_before_reset");
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    ticks_seen = 0;
    expect_at(1, K_STAT, 8'b01, "abort_status");
    expect_at(1, K_PIX, {C_OFF, 2'b11}, "abort_rgb");
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    probe(0, 304, 80, C_P1, "cursor_after_reset");
    probe(0, 336, 320, C_BG, "cell_after_reset");
    check_status(0, 8'b01, "status_after_reset");

    // Every queued expectation must have been consumed
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
